// File: rtl/instr_encoder_loader_if.sv
// Field-bundle handshake between an instruction producer and the loader.
//   master : producer side (drives in_valid, in_last and the decoded fields)
//   slave  : loader side (drives in_ready)
interface instr_encoder_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;

  modport master (
    output in_valid, in_last, op, funct3, funct7_5, rd, rs1, rs2, imm,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_last, op, funct3, funct7_5, rd, rs1, rs2, imm,
    output in_ready
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Sequential RV32I instruction encoder and program loader.
// Packs decoded field bundles into 32-bit words, writes them to instruction memory at
// consecutive word addresses, and holds the core in reset until loading completes.
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   start            : begins a load session (honoured in IDLE/DONE only)
//   bus (slave)      : valid/ready field bundle (op, funct3, funct7_5, rd, rs1, rs2, imm, last)
//   mem_we/addr/wdata: imem write port, one-cycle strobe per legal bundle
//   core_hold, done  : core reset hold, load-finished flag
//   err, err_count   : sticky reject flag and saturating reject count
module instr_encoder_loader #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  instr_encoder_loader_if.slave  bus,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [31:0]            mem_wdata,
  output logic                   core_hold,
  output logic                   done,
  output logic                   err,
  output logic [7:0]             err_count
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  localparam logic [6:0] OpR    = 7'b0110011;
  localparam logic [6:0] OpImm  = 7'b0010011;
  localparam logic [6:0] OpLoad = 7'b0000011;
  localparam logic [6:0] OpS    = 7'b0100011;
  localparam logic [6:0] OpB    = 7'b1100011;
  localparam logic [6:0] OpJ    = 7'b1101111;

  typedef enum logic [1:0] {StIdle, StLoad, StFlush, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic              ready;
  logic              accept;
  logic              start_ok;
  logic              legal;
  logic [31:0]       enc;
  logic signed [31:0] imm_s;

  // in_ready depends only on registered state, never on in_valid.
  assign ready    = (state_q == StLoad) && (count_q < CntW'(DEPTH));
  assign accept   = bus.in_valid && ready;
  assign start_ok = start && ((state_q == StIdle) || (state_q == StDone));
  assign imm_s    = bus.imm;

  // Field packing and immediate range checks.
  always_comb begin
    enc   = '0;
    legal = 1'b0;
    case (bus.op)
      OpR: begin
        enc   = {1'b0, bus.funct7_5, 5'b0, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.op};
        legal = 1'b1;
      end
      OpImm, OpLoad: begin
        if (bus.op == OpImm && (bus.funct3 == 3'b001 || bus.funct3 == 3'b101)) begin
          enc   = {1'b0, bus.funct7_5, 5'b0, bus.imm[4:0], bus.rs1, bus.funct3, bus.rd, bus.op};
          legal = (imm_s >= 32'sd0) && (imm_s <= 32'sd31);
        end else begin
          enc   = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.op};
          legal = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
        end
      end
      OpS: begin
        enc   = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.op};
        legal = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
      end
      OpB: begin
        enc   = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                 bus.imm[4:1], bus.imm[11], bus.op};
        legal = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !bus.imm[0];
      end
      OpJ: begin
        enc   = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12], bus.rd, bus.op};
        legal = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !bus.imm[0];
      end
      default: begin
        enc   = '0;
        legal = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StLoad;
      StLoad: begin
        // Last bundle and filling the final slot collapse into one transition.
        if (accept && (bus.in_last || (legal && count_q == CntW'(DEPTH - 1)))) begin
          state_d = StFlush;
        end
      end
      // Stay until the pending write strobe has been issued.
      StFlush: if (!we_q) state_d = StDone;
      StDone:  if (start) state_d = StLoad;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    bus.in_ready = ready;
    done         = (state_q == StDone);
    core_hold    = (state_q != StDone);
  end

  // Write stage, word counter and error bookkeeping.
  always_comb begin
    we_d      = accept && legal;
    count_d   = count_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    if (start_ok) begin
      count_d   = '0;
      addr_d    = '0;
      err_d     = 1'b0;
      err_cnt_d = '0;
    end else if (accept) begin
      if (legal) begin
        addr_d  = ADDR_W'({count_q, 2'b00});
        wdata_d = enc;
        count_d = count_q + 1'b1;
      end else begin
        err_d = 1'b1;
        if (err_cnt_q != 8'hff) err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      count_q   <= count_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign err       = err_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader with DEPTH=4 and hand-computed encodings.
module tb_instr_encoder_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        core_hold;
  logic        done;
  logic        err;
  logic [7:0]  err_count;

  int unsigned n_vec;
  int unsigned n_miss;

  instr_encoder_loader_if bus ();

  instr_encoder_loader #(
    .DEPTH  (4),
    .ADDR_W (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus.slave),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .core_hold (core_hold),
    .done      (done),
    .err       (err),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one bundle, expect it accepted, then check the write stage after the edge.
  task automatic push(input string tag, input logic [6:0] op, input logic [2:0] f3,
                      input logic f7, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm, input logic last,
                      input logic exp_we, input logic [31:0] exp_addr,
                      input logic [31:0] exp_data);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    bus.op       = op;
    bus.funct3   = f3;
    bus.funct7_5 = f7;
    bus.rd       = rd;
    bus.rs1      = rs1;
    bus.rs2      = rs2;
    bus.imm      = imm;
    check_eq({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check_eq({tag, "_we"}, 32'(mem_we), 32'(exp_we));
    check_eq({tag, "_addr"}, 32'(mem_addr), exp_addr);
    if (exp_we) check_eq({tag, "_data"}, mem_wdata, exp_data);
  endtask

  task automatic do_start(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq({tag, "_hold"}, 32'(core_hold), 32'd1);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_err"}, 32'(err), 32'd0);
    check_eq({tag, "_errcnt"}, 32'(err_count), 32'd0);
    check_eq({tag, "_addr"}, 32'(mem_addr), 32'd0);
  endtask

  // Called just after the last accept edge: write this cycle, done two edges after accept.
  task automatic expect_finish(input string tag);
    check_eq({tag, "_hold0"}, 32'(core_hold), 32'd1);
    check_eq({tag, "_done0"}, 32'(done), 32'd0);
    @(posedge clk);
    #1;
    check_eq({tag, "_we1"}, 32'(mem_we), 32'd0);
    check_eq({tag, "_done1"}, 32'(done), 32'd0);
    check_eq({tag, "_rdy1"}, 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    check_eq({tag, "_done2"}, 32'(done), 32'd1);
    check_eq({tag, "_hold2"}, 32'(core_hold), 32'd0);
  endtask

  initial begin
    n_vec        = 0;
    n_miss       = 0;
    reset        = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.op       = '0;
    bus.funct3   = '0;
    bus.funct7_5 = 1'b0;
    bus.rd       = '0;
    bus.rs1      = '0;
    bus.rs2      = '0;
    bus.imm      = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_rdy", 32'(bus.in_ready), 32'd0);
    check_eq("rst_we", 32'(mem_we), 32'd0);
    check_eq("rst_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_data", mem_wdata, 32'd0);
    check_eq("rst_hold", 32'(core_hold), 32'd1);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_errcnt", 32'(err_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // add then sub (last)
    do_start("s1");
    push("add", 7'b0110011, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b1, 32'd0,
         32'h002081B3);
    push("sub", 7'b0110011, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 1'b1, 32'd4,
         32'h402081B3);
    expect_finish("s1");

    // Format checks; fourth word also fills DEPTH together with in_last
    do_start("s2");
    push("lw", 7'b0000011, 3'b010, 1'b0, 5'd5, 5'd2, 5'd0, 32'd8, 1'b0, 1'b1, 32'd0,
         32'h00812283);
    push("sw", 7'b0100011, 3'b010, 1'b0, 5'd0, 5'd2, 5'd5, -32'sd4, 1'b0, 1'b1, 32'd4,
         32'hFE512E23);
    push("beq", 7'b1100011, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, -32'sd8, 1'b0, 1'b1, 32'd8,
         32'hFE208CE3);
    push("jal", 7'b1101111, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b1, 1'b1, 32'd12,
         32'h001000EF);
    expect_finish("s2");

    // Shift encoding and rejections
    do_start("s3");
    push("srai", 7'b0010011, 3'b101, 1'b1, 5'd4, 5'd4, 5'd0, 32'd3, 1'b0, 1'b1, 32'd0,
         32'h40325213);
    push("rj_beq", 7'b1100011, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0, 1'b0, 32'd0,
         32'd0);
    check_eq("rj_beq_err", 32'(err), 32'd1);
    check_eq("rj_beq_cnt", 32'(err_count), 32'd1);
    push("rj_addi", 7'b0010011, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 1'b0, 32'd0,
         32'd0);
    check_eq("rj_addi_cnt", 32'(err_count), 32'd2);
    push("rj_op", 7'b0110111, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0,
         32'd0);
    check_eq("rj_op_cnt", 32'(err_count), 32'd3);
    check_eq("rj_op_err", 32'(err), 32'd1);
    push("addi", 7'b0010011, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 1'b1, 32'd4,
         32'h00500093);
    expect_finish("s3");

    // Back-to-back to DEPTH without in_last; start in DONE clears err
    do_start("s4");
    for (int i = 0; i < 4; i++) begin
      push("b2b", 7'b0110011, 3'b000, 1'b0, 5'(i + 1), 5'd1, 5'd2, 32'd0, 1'b0, 1'b1,
           32'(4 * i), {20'h00208, 5'(i + 1), 7'b0110011});
    end
    check_eq("b2b_rdy_drop", 32'(bus.in_ready), 32'd0);
    expect_finish("s4");

    // Reset the cycle after an accept
    do_start("s5");
    push("pre_rst", 7'b0110011, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b1, 32'd0,
         32'h002081B3);
    reset = 1'b1;
    #1;
    check_eq("mr_we", 32'(mem_we), 32'd0);
    check_eq("mr_hold", 32'(core_hold), 32'd1);
    check_eq("mr_rdy", 32'(bus.in_ready), 32'd0);
    check_eq("mr_addr", 32'(mem_addr), 32'd0);
    check_eq("mr_data", mem_wdata, 32'd0);
    check_eq("mr_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    check_eq("mr_we2", 32'(mem_we), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    do_start("s6");
    push("reload", 7'b0000011, 3'b010, 1'b0, 5'd5, 5'd2, 5'd0, 32'd8, 1'b1, 1'b1, 32'd0,
         32'h00812283);
    expect_finish("s6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
